// File: rtl/ce_rs_gen_mu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : ce_rs_gen_mu
// Brief   : Multi-UE ZC reference-signal sample generator. It produces ROM
//           addresses with a cyclic shift, realigns the ROM data with the
//           framing tags and can output the saturated conjugate.
// Revision: 1.0  initial release
// ============================================================================
module ce_rs_gen_mu #(
    parameter int wDataOut = 18,
    parameter int wLen     = 12,
    parameter int MAX_LEN  = 2048,
    parameter int NUM_UE   = 2,
    parameter int ROM_LAT  = 1,
    parameter int wAddr    = $clog2(NUM_UE * MAX_LEN),
    parameter int wUe      = (NUM_UE > 1) ? $clog2(NUM_UE) : 1
) (
    input  logic                clk,
    input  logic                rst_n_sync,
    input  logic                sink_valid,
    input  logic                sink_sop,
    input  logic [wLen-1:0]     fftpts_in,
    input  logic [wUe-1:0]      ue_sel,
    input  logic [wLen-1:0]     cyc_shift,
    input  logic                conj_en,
    output logic [wAddr-1:0]    rom_addr,
    input  logic [wDataOut-1:0] rom_real_in,
    input  logic [wDataOut-1:0] rom_imag_in,
    output logic                source_valid,
    output logic                source_sop,
    output logic                source_eop,
    output logic [wDataOut-1:0] source_real,
    output logic [wDataOut-1:0] source_imag,
    output logic                err
);

    localparam logic [0:0]          ST_IDLE   = 1'b0;
    localparam logic [0:0]          ST_RUN    = 1'b1;
    localparam logic [wLen:0]       C_MAX_LEN = (wLen+1)'(MAX_LEN);
    localparam logic [wAddr-1:0]    C_SLOT    = wAddr'(MAX_LEN);
    localparam logic [wLen-1:0]     C_ONE     = wLen'(1);
    localparam logic [wDataOut-1:0] C_NEG_MIN = {1'b1, {(wDataOut-1){1'b0}}};
    localparam logic [wDataOut-1:0] C_POS_MAX = {1'b0, {(wDataOut-1){1'b1}}};

    // ------------------------------------------------------------------
    // Symbol context
    // ------------------------------------------------------------------
    logic [0:0]      state_q, state_d;
    logic [wLen-1:0] len_q,   len_d;
    logic [wLen-1:0] idx_q,   idx_d;
    logic [wLen-1:0] n_q,     n_d;
    logic [wUe-1:0]  ue_q,    ue_d;
    logic            conj_q,  conj_d;
    logic            err_q,   err_d;
    logic [wAddr-1:0] rom_addr_q, rom_addr_d;

    // Current request decoded from the handshake
    logic            w_req_vld;
    logic            w_req_sop;
    logic            w_req_eop;
    logic            w_req_conj;
    logic [wLen-1:0] w_req_idx;
    logic [wUe-1:0]  w_req_ue;

    logic            w_len_ok;
    logic            w_cs_bad;
    logic [wLen-1:0] w_cs_eff;

    function automatic logic [wLen-1:0] next_idx(input logic [wLen-1:0] i,
                                                 input logic [wLen-1:0] l);
        return (i == l - C_ONE) ? '0 : i + C_ONE;
    endfunction

    always_comb begin
        w_len_ok = (fftpts_in != '0) && ({1'b0, fftpts_in} <= C_MAX_LEN);
        w_cs_bad = (cyc_shift >= fftpts_in);
        w_cs_eff = w_cs_bad ? '0 : cyc_shift;
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        n_d        = n_q;
        ue_d       = ue_q;
        conj_d     = conj_q;
        err_d      = 1'b0;
        w_req_vld  = 1'b0;
        w_req_sop  = 1'b0;
        w_req_eop  = 1'b0;
        w_req_idx  = idx_q;
        w_req_ue   = ue_q;
        w_req_conj = conj_q;

        if (sink_valid && sink_sop) begin
            // A sop always restarts; anything in progress is abandoned here.
            if (state_q == ST_RUN) begin
                err_d = 1'b1;
            end
            if (!w_len_ok) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end else begin
                if (w_cs_bad) begin
                    err_d = 1'b1;
                end
                w_req_vld  = 1'b1;
                w_req_sop  = 1'b1;
                w_req_eop  = (fftpts_in == C_ONE);
                w_req_idx  = w_cs_eff;
                w_req_ue   = ue_sel;
                w_req_conj = conj_en;
                len_d      = fftpts_in;
                ue_d       = ue_sel;
                conj_d     = conj_en;
                idx_d      = next_idx(w_cs_eff, fftpts_in);
                n_d        = (fftpts_in == C_ONE) ? '0 : C_ONE;
                state_d    = (fftpts_in == C_ONE) ? ST_IDLE : ST_RUN;
            end
        end else if (sink_valid) begin
            if (state_q == ST_RUN) begin
                w_req_vld = 1'b1;
                w_req_eop = (n_q == len_q - C_ONE);
                idx_d     = next_idx(idx_q, len_q);
                n_d       = w_req_eop ? '0 : n_q + C_ONE;
                if (w_req_eop) begin
                    state_d = ST_IDLE;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        rom_addr_d = rom_addr_q;
        if (w_req_vld) begin
            rom_addr_d = (wAddr'(w_req_ue) * C_SLOT) + wAddr'(w_req_idx);
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline: stage 0 is aligned with rom_addr, stage ROM_LAT with
    // the ROM data returned for that address.
    // ------------------------------------------------------------------
    logic [ROM_LAT:0] vld_pipe_q,  vld_pipe_d;
    logic [ROM_LAT:0] sop_pipe_q,  sop_pipe_d;
    logic [ROM_LAT:0] eop_pipe_q,  eop_pipe_d;
    logic [ROM_LAT:0] conj_pipe_q, conj_pipe_d;

    always_comb begin
        vld_pipe_d  = {vld_pipe_q[ROM_LAT-1:0],  w_req_vld};
        sop_pipe_d  = {sop_pipe_q[ROM_LAT-1:0],  w_req_vld & w_req_sop};
        eop_pipe_d  = {eop_pipe_q[ROM_LAT-1:0],  w_req_vld & w_req_eop};
        conj_pipe_d = {conj_pipe_q[ROM_LAT-1:0], w_req_conj};
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic                src_valid_q, src_valid_d;
    logic                src_sop_q,   src_sop_d;
    logic                src_eop_q,   src_eop_d;
    logic [wDataOut-1:0] src_real_q,  src_real_d;
    logic [wDataOut-1:0] src_imag_q,  src_imag_d;
    logic [wDataOut-1:0] w_imag_neg;

    always_comb begin
        // Negating the most-negative code would wrap, so clamp it.
        w_imag_neg = (rom_imag_in == C_NEG_MIN) ? C_POS_MAX
                                                : (~rom_imag_in) + wDataOut'(1);
        src_valid_d = vld_pipe_q[ROM_LAT];
        src_sop_d   = vld_pipe_q[ROM_LAT] & sop_pipe_q[ROM_LAT];
        src_eop_d   = vld_pipe_q[ROM_LAT] & eop_pipe_q[ROM_LAT];
        src_real_d  = src_real_q;
        src_imag_d  = src_imag_q;
        if (vld_pipe_q[ROM_LAT]) begin
            src_real_d = rom_real_in;
            src_imag_d = conj_pipe_q[ROM_LAT] ? w_imag_neg : rom_imag_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            n_q         <= '0;
            ue_q        <= '0;
            conj_q      <= 1'b0;
            err_q       <= 1'b0;
            rom_addr_q  <= '0;
            vld_pipe_q  <= '0;
            sop_pipe_q  <= '0;
            eop_pipe_q  <= '0;
            conj_pipe_q <= '0;
            src_valid_q <= 1'b0;
            src_sop_q   <= 1'b0;
            src_eop_q   <= 1'b0;
            src_real_q  <= '0;
            src_imag_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            n_q         <= n_d;
            ue_q        <= ue_d;
            conj_q      <= conj_d;
            err_q       <= err_d;
            rom_addr_q  <= rom_addr_d;
            vld_pipe_q  <= vld_pipe_d;
            sop_pipe_q  <= sop_pipe_d;
            eop_pipe_q  <= eop_pipe_d;
            conj_pipe_q <= conj_pipe_d;
            src_valid_q <= src_valid_d;
            src_sop_q   <= src_sop_d;
            src_eop_q   <= src_eop_d;
            src_real_q  <= src_real_d;
            src_imag_q  <= src_imag_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign err          = err_q;
    assign source_valid = src_valid_q;
    assign source_sop   = src_sop_q;
    assign source_eop   = src_eop_q;
    assign source_real  = src_real_q;
    assign source_imag  = src_imag_q;

endmodule
`default_nettype wire

// File: tb/tb_ce_rs_gen_mu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_ce_rs_gen_mu
// Brief   : Directed self-checking bench for ce_rs_gen_mu with a ROM model.
// Revision: 1.0  initial release
// ============================================================================
module tb_ce_rs_gen_mu;

    localparam int W  = 18;
    localparam int WL = 12;
    localparam int ML = 2048;
    localparam int NU = 2;
    localparam int RL = 1;
    localparam int WA = 12;

    logic          clk = 1'b0;
    logic          rst_n_sync;
    logic          sink_valid;
    logic          sink_sop;
    logic [WL-1:0] fftpts_in;
    logic [0:0]    ue_sel;
    logic [WL-1:0] cyc_shift;
    logic          conj_en;
    logic [WA-1:0] rom_addr;
    logic [W-1:0]  rom_real_in;
    logic [W-1:0]  rom_imag_in;
    logic          source_valid;
    logic          source_sop;
    logic          source_eop;
    logic [W-1:0]  source_real;
    logic [W-1:0]  source_imag;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int t0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ce_rs_gen_mu #(
        .wDataOut (W),
        .wLen     (WL),
        .MAX_LEN  (ML),
        .NUM_UE   (NU),
        .ROM_LAT  (RL),
        .wAddr    (WA)
    ) u_dut (
        .clk          (clk),
        .rst_n_sync   (rst_n_sync),
        .sink_valid   (sink_valid),
        .sink_sop     (sink_sop),
        .fftpts_in    (fftpts_in),
        .ue_sel       (ue_sel),
        .cyc_shift    (cyc_shift),
        .conj_en      (conj_en),
        .rom_addr     (rom_addr),
        .rom_real_in  (rom_real_in),
        .rom_imag_in  (rom_imag_in),
        .source_valid (source_valid),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_real  (source_real),
        .source_imag  (source_imag),
        .err          (err)
    );

    // ROM model: real = address, imag has two special codes for the conjugate test.
    function automatic logic [W-1:0] rom_re(input logic [WA-1:0] a);
        return W'(a);
    endfunction

    function automatic logic [W-1:0] rom_im(input logic [WA-1:0] a);
        if (a == 0) return 18'h20000;
        if (a == 1) return 18'd5;
        return W'(a) + W'(1000);
    endfunction

    always @(posedge clk) begin
        rom_real_in <= rom_re(rom_addr);
        rom_imag_in <= rom_im(rom_addr);
    end

    typedef struct {
        logic [37:0] d;
        int          c;
    } smp_t;

    smp_t        obs_q[$];
    logic [37:0] exp_q[$];
    smp_t        mon_s;

    always @(negedge clk) begin
        if (rst_n_sync && source_valid) begin
            mon_s.d = {source_sop, source_eop, source_real, source_imag};
            mon_s.c = cyc;
            obs_q.push_back(mon_s);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [37:0] pk(input logic s, input logic e,
                                       input logic [W-1:0] re, input logic [W-1:0] im);
        return {s, e, re, im};
    endfunction

    function automatic int obs_c(input int i);
        if (i < obs_q.size()) return obs_q[i].c;
        return -1;
    endfunction

    task automatic step(input logic v, input logic s, input logic [WL-1:0] l,
                        input logic [0:0] ue, input logic [WL-1:0] cs, input logic cj);
        sink_valid = v;
        sink_sop   = s;
        fftpts_in  = l;
        ue_sel     = ue;
        cyc_shift  = cs;
        conj_en    = cj;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic compare_out(input string tag);
        check_eq({tag, "_cnt"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check_eq($sformatf("%s_s%0d", tag, i), 64'(obs_q[i].d), 64'(exp_q[i]));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_sync = 1'b0;
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        fftpts_in  = '0;
        ue_sel     = '0;
        cyc_shift  = '0;
        conj_en    = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst_valid", 64'(source_valid), 64'd0);
        check_eq("rst_addr",  64'(rom_addr),     64'd0);
        check_eq("rst_err",   64'(err),          64'd0);
        check_eq("rst_real",  64'(source_real),  64'd0);
        rst_n_sync = 1'b1;
        idle(2);

        // Basic symbol followed by a shifted UE1 symbol with no bubble
        t0 = cyc;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, i == 0, 12'd12, 1'b0, 12'd0, 1'b0);
            check_eq($sformatf("basic_addr%0d", i), 64'(rom_addr), 64'(i));
            check_eq($sformatf("basic_err%0d", i), 64'(err), 64'd0);
            exp_q.push_back(pk(i == 0, i == 11, rom_re(WA'(i)), rom_im(WA'(i))));
        end
        for (int k = 0; k < 12; k++) begin
            step(1'b1, k == 0, 12'd12, 1'b1, 12'd5, 1'b0);
            check_eq($sformatf("shift_addr%0d", k), 64'(rom_addr),
                     64'(2048 + ((5 + k) % 12)));
            exp_q.push_back(pk(k == 0, k == 11, rom_re(WA'(2048 + ((5 + k) % 12))),
                               rom_im(WA'(2048 + ((5 + k) % 12)))));
        end
        idle(6);
        check_eq("basic_lat",    64'(obs_c(0)),  64'(t0 + 3));
        check_eq("basic_last",   64'(obs_c(11)), 64'(t0 + 14));
        check_eq("b2b_nobubble", 64'(obs_c(12)), 64'(t0 + 15));
        compare_out("basic_shift");

        // Stall with conjugate
        t0 = cyc;
        step(1'b1, 1'b1, 12'd4, 1'b0, 12'd0, 1'b1);
        step(1'b0, 1'b0, 12'd4, 1'b0, 12'd0, 1'b0);
        step(1'b0, 1'b0, 12'd4, 1'b0, 12'd0, 1'b0);
        check_eq("stall_addr_hold", 64'(rom_addr), 64'd0);
        step(1'b1, 1'b0, 12'd4, 1'b0, 12'd0, 1'b0);
        step(1'b1, 1'b0, 12'd4, 1'b0, 12'd0, 1'b0);
        step(1'b1, 1'b0, 12'd4, 1'b0, 12'd0, 1'b0);
        idle(6);
        check_eq("stall_first", 64'(obs_c(0)), 64'(t0 + 3));
        check_eq("stall_gap",   64'(obs_c(1)), 64'(t0 + 6));
        exp_q.push_back(pk(1'b1, 1'b0, 18'd0, 18'h1FFFF));
        exp_q.push_back(pk(1'b0, 1'b0, 18'd1, 18'h3FFFB));
        exp_q.push_back(pk(1'b0, 1'b0, 18'd2, 18'h3FC16));
        exp_q.push_back(pk(1'b0, 1'b1, 18'd3, 18'h3FC15));
        compare_out("conj");

        // Abort with a new sop at n=3
        step(1'b1, 1'b1, 12'd8, 1'b0, 12'd0, 1'b0);
        check_eq("abort_err0", 64'(err), 64'd0);
        step(1'b1, 1'b0, 12'd8, 1'b0, 12'd0, 1'b0);
        step(1'b1, 1'b0, 12'd8, 1'b0, 12'd0, 1'b0);
        step(1'b1, 1'b1, 12'd2, 1'b0, 12'd0, 1'b0);
        check_eq("abort_err", 64'(err), 64'd1);
        step(1'b1, 1'b0, 12'd2, 1'b0, 12'd0, 1'b0);
        check_eq("abort_err_clr", 64'(err), 64'd0);
        idle(6);
        exp_q.push_back(pk(1'b1, 1'b0, rom_re(12'd0), rom_im(12'd0)));
        exp_q.push_back(pk(1'b0, 1'b0, rom_re(12'd1), rom_im(12'd1)));
        exp_q.push_back(pk(1'b0, 1'b0, rom_re(12'd2), rom_im(12'd2)));
        exp_q.push_back(pk(1'b1, 1'b0, rom_re(12'd0), rom_im(12'd0)));
        exp_q.push_back(pk(1'b0, 1'b1, rom_re(12'd1), rom_im(12'd1)));
        compare_out("abort");

        // Illegal lengths
        step(1'b1, 1'b1, 12'd0, 1'b0, 12'd0, 1'b0);
        check_eq("len0_err", 64'(err), 64'd1);
        idle(1);
        check_eq("len0_err_pulse", 64'(err), 64'd0);
        idle(4);
        step(1'b1, 1'b1, 12'd2049, 1'b0, 12'd0, 1'b0);
        check_eq("len2049_err", 64'(err), 64'd1);
        idle(6);
        compare_out("illegal_len");

        // Shift >= length is treated as zero
        for (int i = 0; i < 6; i++) begin
            step(1'b1, i == 0, 12'd6, 1'b0, 12'd7, 1'b0);
            check_eq($sformatf("cs_addr%0d", i), 64'(rom_addr), 64'(i));
            exp_q.push_back(pk(i == 0, i == 5, rom_re(WA'(i)), rom_im(WA'(i))));
            if (i == 0) check_eq("cs_err", 64'(err), 64'd1);
        end
        idle(6);
        compare_out("cs_big");

        // Asynchronous reset mid-symbol
        for (int i = 0; i < 5; i++) begin
            step(1'b1, i == 0, 12'd8, 1'b0, 12'd0, 1'b0);
        end
        #2 rst_n_sync = 1'b0;
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        #1;
        check_eq("arst_valid", 64'(source_valid), 64'd0);
        check_eq("arst_addr",  64'(rom_addr),     64'd0);
        check_eq("arst_real",  64'(source_real),  64'd0);
        check_eq("arst_imag",  64'(source_imag),  64'd0);
        check_eq("arst_sop",   64'(source_sop),   64'd0);
        obs_q.delete();
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n_sync = 1'b1;
        step(1'b1, 1'b0, 12'd8, 1'b0, 12'd0, 1'b0);
        check_eq("arst_nosop_err", 64'(err), 64'd1);
        idle(6);
        check_eq("arst_addr_after", 64'(rom_addr), 64'd0);
        compare_out("arst_tail");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ce_rs_gen_mu.md
Name: ce_rs_gen_mu

Overview:
- Multi-UE, parametrised reference-signal (ZC) sample generator for the CE transmit/LS path.
- Per symbol, it produces ROM addresses for one UE's stored sequence, applies a cyclic shift modulo the symbol length, and realigns the external ROM read data with valid/sop/eop framing.
- Optional conjugation with saturation supports the LS divider on the receive side.
- Sits between the CE control sequencer and the LS estimator; the sequence ROMs sit outside this block.

Parameters:
- wDataOut, 18, sample width (two's complement) of real/imag data.
- wLen, 12, width of the length, shift and counter fields.
- MAX_LEN, 2048, ROM slot size per UE; largest legal symbol length.
- NUM_UE, 2, number of UE sequences stored back to back in the ROM.
- ROM_LAT, 1, external ROM read latency in clocks (1..4).
- wAddr, clog2(NUM_UE*MAX_LEN), ROM address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n_sync  in  1  reset, asynchronous assert, active-low.
- sink_valid  in  1  request one sample this cycle; low = stall (state held).
- sink_sop  in  1  first request of a symbol; parameters are captured here.
- fftpts_in  in  wLen  symbol length L, sampled with sink_sop.
- ue_sel  in  clog2(NUM_UE)  UE index, sampled with sink_sop.
- cyc_shift  in  wLen  cyclic shift CS, sampled with sink_sop.
- conj_en  in  1  output conjugate, sampled with sink_sop.
- rom_addr  out  wAddr  ROM read address (registered).
- rom_real_in  in  wDataOut  ROM real data, ROM_LAT clocks after rom_addr.
- rom_imag_in  in  wDataOut  ROM imag data, same timing as rom_real_in.
- source_valid  out  1  output sample valid.
- source_sop  out  1  first sample of symbol.
- source_eop  out  1  last sample of symbol.
- source_real  out  wDataOut  output real part.
- source_imag  out  wDataOut  output imag part, conjugated if captured conj_en=1.
- err  out  1  one-cycle pulse on a protocol or parameter error.

Behaviour:
- Reset: all outputs 0, counters 0, state IDLE. Reset asserted mid-symbol aborts immediately; no partial tail is emitted after release.
- States:
  - IDLE: waits for sink_valid & sink_sop.
  - RUN: symbol in progress.
- Capture, on an accepted sop:
  - L is legal when 1 <= L <= MAX_LEN, else err pulses, the request is dropped and the state stays or returns to IDLE.
  - CS >= L: err pulses, CS is treated as 0 and the symbol proceeds.
- Address generation per accepted request (sink_valid=1 in RUN, or the accepting sop):
  - idx starts at CS and increments; L-1 wraps to 0.
  - rom_addr = ue*MAX_LEN + idx, registered, so it appears 1 clock after the request.
  - Sample counter n runs 0..L-1.
  - n=0 tags sop; n=L-1 tags eop, then the state returns to IDLE.
- Stall: sink_valid=0 in RUN holds idx and n. rom_addr holds its last value. No output valid is generated for that slot.
- sink_valid without sink_sop while IDLE: ignored; err pulses.
- sink_sop while RUN: the current symbol is aborted and err pulses. The new sop is captured in the same cycle and starts a fresh symbol. Any eop of the aborted symbol is never emitted; samples already in the pipeline still drain.
- sop and eop on the same request (L=1): both flags set on that sample.
- Back-to-back symbols: a sop in the cycle after an eop request is accepted with no bubble.
- Pipeline:
  - Tags (valid/sop/eop/conj) are delayed ROM_LAT clocks to meet the ROM data.
  - The output register adds 1 clock.
  - Total latency from request to source_*: ROM_LAT+2 clocks.
- Conjugate: source_imag = -rom_imag_in. The most-negative value saturates to +(2^(wDataOut-1)-1). source_real passes through.
- When source_valid=0: source_real/source_imag hold their previous values; sop/eop are 0.

Test Plan:
- Basic: reset, then L=12, ue=0, CS=0, 12 consecutive requests -> rom_addr 0..11. Data appears 3 clocks after each request (ROM_LAT=1). sop on the first sample, eop on the 12th.
- Shift + UE: L=12, ue=1, CS=5 -> rom_addr 2053..2059, then 2048..2052. eop on the sample from addr 2052.
- Stall + conjugate: L=4, conj_en=1, sink_valid 1,0,0,1,1,1 -> 4 output samples with a 2-cycle gap. A ROM imag of -131072 gives +131071; 5 gives -5.
- Abort: L=8, sop again at n=3 with L=2 -> err pulse. Outputs are 3 samples without eop, then 2 samples with sop/eop.
- Illegal params: L=0 -> err, no output. L=2049 -> err, no output. L=6 with CS=7 -> err, addresses start at 0.
- Async reset mid-symbol at n=5 -> all outputs 0 immediately. After release, sink_valid without sop gives err and no output.
